wb_uart_lite: RTL and testbench

WB_UART_LITE -- requirements
Module: wb_uart_lite

---
 rtl/wb_uart_lite_if.sv | 22 ++
 rtl/wb_uart_lite.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wb_uart_lite.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_lite_if.sv
// wb_uart_lite_if: Wishbone classic request/response bundle for the UART register block
interface wb_uart_lite_if;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_uart_lite.sv
// wb_uart_lite: Wishbone-attached 8N1 UART with TX FIFO, single-byte RX holding register and runtime divisor
module wb_uart_lite #(
    parameter int unsigned DEFAULT_DIVISOR = 207,
    parameter int unsigned TX_FIFO_AW      = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    wb_uart_lite_if.slave wb,
    input  logic          uart_rx,
    output logic          uart_tx
);
    localparam int unsigned DEPTH = 1 << TX_FIFO_AW;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                  req, wr_data, wr_div, rd_data, rd_stat;
    logic [1:0]            reg_sel;
    logic [31:0]           rdata;
    logic [15:0]           divisor;
    logic [7:0]            mem [DEPTH];
    logic [TX_FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [TX_FIFO_AW:0]   count;
    logic                  full, empty, push, tx_pop, tx_idle;
    logic [7:0]            head;
    state_t                tx_state, tx_state_n;
    logic [15:0]           tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]            tx_bit, tx_bit_n;
    logic [7:0]            tx_sh, tx_sh_n;
    logic                  tx_n, tx_end;
    logic                  rx_s1, rx_s2, rx_s3, rx_fall;
    state_t                rx_state, rx_state_n;
    logic [15:0]           rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]            rx_bit, rx_bit_n;
    logic [7:0]            rx_sh, rx_sh_n, rx_byte;
    logic [16:0]           rx_mid;
    logic                  rx_half, rx_end, rx_done;
    logic                  rx_valid, rx_overrun, rx_frame_err;
    logic                  unused;

    assign unused  = &{1'b0, wb.wb_dat_i[31:16], wb.wb_sel_i[3:2], wb.wb_adr_i[1:0]};
    assign wb.wb_err_o = 1'b0;

    // a request is taken only while no ack is outstanding, so accesses pair up with acks one to one
    assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign reg_sel = wb.wb_adr_i[3:2];
    assign wr_data = req & wb.wb_we_i & (reg_sel == 2'd0) & wb.wb_sel_i[0];
    assign wr_div  = req & wb.wb_we_i & (reg_sel == 2'd2);
    assign rd_data = req & ~wb.wb_we_i & (reg_sel == 2'd0);
    assign rd_stat = req & ~wb.wb_we_i & (reg_sel == 2'd1);

    assign full    = count[TX_FIFO_AW];
    assign empty   = (count == '0);
    assign push    = wr_data & (~full | tx_pop);
    assign head    = mem[rd_ptr];
    assign tx_idle = empty & (tx_state == IDLE);

    // read mux for the register file; reserved slot reads zero
    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            2'd0:    rdata = {24'h0, rx_byte};
            2'd1:    rdata = {27'h0, rx_frame_err, rx_overrun, rx_valid, tx_idle, full};
            2'd2:    rdata = {16'h0, divisor};
            default: rdata = 32'h0;
        endcase
    end

    // registered Wishbone response and the byte-gated divisor register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= 32'h0;
            divisor     <= 16'(DEFAULT_DIVISOR);
        end else begin
            wb.wb_ack_o <= req;
            wb.wb_dat_o <= req ? rdata : 32'h0;
            if (wr_div && wb.wb_sel_i[0]) divisor[7:0]  <= wb.wb_dat_i[7:0];
            if (wr_div && wb.wb_sel_i[1]) divisor[15:8] <= wb.wb_dat_i[15:8];
        end
    end

    // FIFO storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= wb.wb_dat_i[7:0];
    end

    // FIFO pointers and occupancy; a push on a full FIFO lands only when the TX engine pops that cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (push & ~tx_pop) ? count + 1'b1 : (~push & tx_pop) ? count - 1'b1 : count;
        end
    end

    assign tx_end = (tx_cnt == tx_div);

    // TX next-state logic; the divisor is relatched at every bit boundary so changes never split a bit
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_n       = uart_tx;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = 16'd0;
                tx_n     = 1'b1;
                if (!empty) begin
                    tx_state_n = START;
                    tx_pop     = 1'b1;
                    tx_sh_n    = head;
                    tx_div_n   = divisor;
                    tx_n       = 1'b0;
                end
            end
            START: if (tx_end) begin
                tx_state_n = DATA;
                tx_cnt_n   = 16'd0;
                tx_div_n   = divisor;
                tx_bit_n   = 3'd0;
                tx_n       = tx_sh[0];
            end
            DATA: if (tx_end) begin
                tx_cnt_n = 16'd0;
                tx_div_n = divisor;
                if (tx_bit == 3'd7) begin
                    tx_state_n = STOP;
                    tx_n       = 1'b1;
                end else begin
                    tx_bit_n = tx_bit + 3'd1;
                    tx_sh_n  = tx_sh >> 1;
                    tx_n     = tx_sh[1];
                end
            end
            STOP: if (tx_end) begin
                tx_cnt_n = 16'd0;
                tx_div_n = divisor;
                if (!empty) begin
                    tx_state_n = START;
                    tx_pop     = 1'b1;
                    tx_sh_n    = head;
                    tx_n       = 1'b0;
                end else begin
                    tx_state_n = IDLE;
                    tx_n       = 1'b1;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // TX state register; uart_tx comes straight from a flop so the line never glitches
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tx_state <= IDLE;
            tx_cnt   <= 16'd0;
            tx_div   <= 16'(DEFAULT_DIVISOR);
            tx_bit   <= 3'd0;
            tx_sh    <= 8'h0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            uart_tx  <= tx_n;
        end
    end

    // two-flop synchronizer plus one history flop for falling-edge detection; all idle high
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 & ~rx_s2;
    assign rx_mid  = ({1'b0, rx_div} + 17'd1) >> 1;
    assign rx_half = ({1'b0, rx_cnt} + 17'd1) >= rx_mid;
    assign rx_end  = (rx_cnt == rx_div);

    // RX next-state logic: mid-bit start check rejects glitches, then one sample per bit period
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_done    = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = 16'd0;
                if (rx_fall) begin
                    rx_state_n = START;
                    rx_div_n   = divisor;
                end
            end
            START: if (rx_half) begin
                rx_state_n = rx_s2 ? IDLE : DATA;
                rx_cnt_n   = 16'd0;
                rx_div_n   = divisor;
                rx_bit_n   = 3'd0;
            end
            DATA: if (rx_end) begin
                rx_cnt_n   = 16'd0;
                rx_div_n   = divisor;
                rx_sh_n    = {rx_s2, rx_sh[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                rx_state_n = (rx_bit == 3'd7) ? STOP : DATA;
            end
            STOP: if (rx_end) begin
                rx_state_n = IDLE;
                rx_cnt_n   = 16'd0;
                rx_done    = 1'b1;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rx_state <= IDLE;
            rx_cnt   <= 16'd0;
            rx_div   <= 16'(DEFAULT_DIVISOR);
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
        end
    end

    // RX holding register and sticky flags; a new byte beats a same-cycle read, and set beats clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rx_byte      <= 8'h0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_done) rx_byte <= rx_sh;
            rx_valid     <= rx_done | (rx_valid & ~rd_data);
            rx_overrun   <= (rx_done & rx_valid & ~rd_data) | (rx_overrun & ~rd_stat);
            rx_frame_err <= (rx_done & ~rx_s2) | (rx_frame_err & ~rd_stat);
        end
    end
endmodule

// File: tb/tb_wb_uart_lite.sv
// tb_wb_uart_lite: register table, serial TX scoreboard and hand-built RX/reset sequences for wb_uart_lite
module tb_wb_uart_lite;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic [31:0] q_exp[$];
    string       q_name[$];
    logic [7:0]  q_tx[$];

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[14];

    always #5 clk = ~clk;

    wb_uart_lite_if bus();

    wb_uart_lite dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wb        (bus),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input logic we, input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        @(negedge clk);
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge clk);
        #1;
        rd = bus.wb_dat_o;
        chk("ack_rise", {30'h0, bus.wb_err_o, bus.wb_ack_o}, 32'h1);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!we) chk(q_name.pop_front(), rd, q_exp.pop_front());
        @(posedge clk);
        #1;
        chk("ack_drop", {bus.wb_dat_o[30:0], bus.wb_ack_o}, 32'h0);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        q_exp.push_back(exp);
        q_name.push_back(name);
        bus_cycle(1'b0, adr, 32'h0, 4'hF);
    endtask

    task automatic tx_wr(input logic [7:0] b);
        q_tx.push_back(b);
        bus_cycle(1'b1, 4'h0, {24'h0, b}, 4'h1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // serial decoder for uart_tx at 4 clocks per bit, sampling mid-bit and checking against queued bytes
    initial begin : mon
        int m_cnt;
        int k;
        logic [7:0] m_sh;
        m_cnt = -1;
        m_sh  = 8'h0;
        forever begin
            @(negedge clk);
            if (!mon_en) m_cnt = -1;
            else if (m_cnt < 0) begin
                if (uart_tx === 1'b0) m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt % 4 == 2) begin
                    k = m_cnt / 4;
                    if (k == 0 && uart_tx !== 1'b0) m_cnt = -1;
                    else if (k >= 1 && k <= 8) m_sh[k-1] = uart_tx;
                    else if (k == 9) begin
                        if (q_tx.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL tx_unexpected: got byte 0x%02h, expected none", m_sh);
                        end else chk("tx_byte", {23'h0, uart_tx, m_sh}, {23'h0, 1'b1, q_tx.pop_front()});
                        m_cnt = -1;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        logic       eb;
        int         low;
        bus.wb_adr_i = 4'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", {29'h0, uart_tx, bus.wb_ack_o, |bus.wb_dat_o}, 32'h4);
        rst_n = 1'b1;

        vt[0]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h2};
        vt[1]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'hCF};
        vt[2]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0};
        vt[3]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};
        vt[4]  = '{1'b1, 4'hC, 32'hDEADBEEF, 4'hF, 32'h0};
        vt[5]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0};
        vt[6]  = '{1'b1, 4'h8, 32'h12345678, 4'h1, 32'h0};
        vt[7]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h78};
        vt[8]  = '{1'b1, 4'h8, 32'h0000ABCD, 4'h2, 32'h0};
        vt[9]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'hAB78};
        vt[10] = '{1'b1, 4'h8, 32'hFFFF0003, 4'hF, 32'h0};
        vt[11] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h3};
        vt[12] = '{1'b1, 4'h0, 32'h00000077, 4'hE, 32'h0};
        vt[13] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h2};
        for (int i = 0; i < 14; i++) begin
            if (vt[i].we) bus_cycle(1'b1, vt[i].adr, vt[i].dat, vt[i].sel);
            else rd(vt[i].adr, vt[i].exp, $sformatf("vec%0d", i));
        end

        mon_en = 1'b1;
        pat = 8'hA5;
        tx_wr(pat);
        for (int k = 0; k < 40; k++) begin
            eb = (k < 4) ? 1'b0 : (k < 36) ? pat[k/4 - 1] : 1'b1;
            chk($sformatf("tx_wave%0d", k), {31'h0, uart_tx}, {31'h0, eb});
            @(posedge clk);
            #1;
        end
        rd(4'h4, 32'h2, "tx_idle_after_frame");

        for (int i = 0; i < 10; i++) begin
            if (i < 9) tx_wr(8'h10 + 8'(i));
            else bus_cycle(1'b1, 4'h0, 32'h19, 4'h1);
            if (i == 7) rd(4'h4, 32'h0, "fifo_7");
            if (i >= 8) rd(4'h4, 32'h1, $sformatf("fifo_full%0d", i));
        end
        repeat (380) @(posedge clk);
        chk("tx_drain", q_tx.size(), 32'h0);
        rd(4'h4, 32'h2, "tx_idle_drained");

        send_rx(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        rd(4'h4, 32'h6, "rx_status");
        rd(4'h0, 32'h3C, "rx_data");
        rd(4'h4, 32'h2, "rx_status_clr");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (3) @(negedge clk);
        rd(4'h0, 32'h22, "ovr_data");
        rd(4'h4, 32'hA, "ovr_status");
        rd(4'h4, 32'h2, "ovr_cleared");
        send_rx(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rd(4'h4, 32'h16, "ferr_status");
        rd(4'h4, 32'h6, "ferr_cleared");
        rd(4'h0, 32'h55, "ferr_data");
        rd(4'h4, 32'h2, "ferr_empty");

        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (50) @(negedge clk);
        rd(4'h4, 32'h2, "glitch_status");
        rd(4'h0, 32'h55, "stale_data");
        rd(4'h4, 32'h2, "stale_status");

        mon_en = 1'b0;
        bus_cycle(1'b1, 4'h0, 32'hA5, 4'h1);
        bus_cycle(1'b1, 4'h0, 32'h3C, 4'h1);
        repeat (15) @(posedge clk);
        #1;
        chk("tx_bit3", {31'h0, uart_tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {30'h0, uart_tx, bus.wb_ack_o}, 32'h2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_tx.delete();
        low = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low++;
        end
        chk("tx_quiet", low, 32'h0);
        rd(4'h4, 32'h2, "rst_status");
        rd(4'h8, 32'hCF, "rst_divisor");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
